// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: operation encodings
// and a helper that sizes the latency down-counter.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MDU_none  = 4'd0,
        MDU_mult  = 4'd1,
        MDU_multu = 4'd2,
        MDU_div   = 4'd3,
        MDU_divu  = 4'd4,
        MDU_mthi  = 4'd5,
        MDU_mtlo  = 4'd6,
        MDU_mfhi  = 4'd7,
        MDU_mflo  = 4'd8,
        MDU_madd  = 4'd9,
        MDU_maddu = 4'd10,
        MDU_msub  = 4'd11,
        MDU_msubu = 4'd12
    } mdu_op_e;

    // Counter must hold the larger latency; never narrower than 4 bits.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m + 1);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage MDU operand/result bundle. The slave side is the MDU itself; the
// master side is the pipeline datapath and hazard unit.
interface e_mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        Req;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Out;

    modport master (
        output A, B, MDUOp, Req,
        input  Start, Busy, HI, LO, Out
    );

    modport slave (
        input  A, B, MDUOp, Req,
        output Start, Busy, HI, LO, Out
    );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO.
// The full result is computed at the issue edge and held in temporaries; HI/LO
// are written only when the latency counter expires, so Busy models the
// multi-cycle latency seen by the hazard unit.
// Optional feature: define MDU_MADD_EN to add madd/maddu/msub/msubu.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic   clk,
    input logic   reset,
    e_mdu_if.slave mdu
);

    localparam int unsigned CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

    mdu_op_e w_op;
    logic    w_is_mul;
    logic    w_is_div;
    logic    w_signed;
    logic    w_is_acc;
    logic    w_is_sub;
    logic    w_start;
    logic    w_div0;

    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic [63:0] w_mul_res;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_tmp_hi;
    logic [31:0]      r_tmp_lo;
    logic             r_wr;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;

    assign w_op = mdu_op_e'(mdu.MDUOp);

    // Decode the op into multiply/divide class and signedness flags.
    always_comb begin
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        w_signed = 1'b0;
        w_is_acc = 1'b0;
        w_is_sub = 1'b0;
        case (w_op)
            MDU_mult:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
            MDU_multu: begin w_is_mul = 1'b1; end
            MDU_div:   begin w_is_div = 1'b1; w_signed = 1'b1; end
            MDU_divu:  begin w_is_div = 1'b1; end
`ifdef MDU_MADD_EN
            MDU_madd:  begin w_is_mul = 1'b1; w_signed = 1'b1; w_is_acc = 1'b1; end
            MDU_maddu: begin w_is_mul = 1'b1; w_is_acc = 1'b1; end
            MDU_msub:  begin
                w_is_mul = 1'b1; w_signed = 1'b1; w_is_acc = 1'b1; w_is_sub = 1'b1;
            end
            MDU_msubu: begin w_is_mul = 1'b1; w_is_acc = 1'b1; w_is_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign w_start = (w_is_mul | w_is_div) & ~mdu.Req;
    assign w_div0  = w_is_div & (mdu.B == 32'd0);

    // Full 64-bit product/accumulate and magnitude-based divide.
    always_comb begin
        w_a_ext   = w_signed ? {{32{mdu.A[31]}}, mdu.A} : {32'd0, mdu.A};
        w_b_ext   = w_signed ? {{32{mdu.B[31]}}, mdu.B} : {32'd0, mdu.B};
        // Low 64 bits of the extended product are correct for both signednesses.
        w_prod    = w_a_ext * w_b_ext;
        w_mul_res = w_prod;
        if (w_is_acc) begin
            w_mul_res = w_is_sub ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
        end

        w_a_neg = w_signed & mdu.A[31];
        w_b_neg = w_signed & mdu.B[31];
        w_a_mag = w_a_neg ? (32'd0 - mdu.A) : mdu.A;
        // Divisor forced to 1 on B==0 so the datapath stays defined; result is discarded.
        w_b_mag = (mdu.B == 32'd0) ? 32'd1 : (w_b_neg ? (32'd0 - mdu.B) : mdu.B);
        w_q_mag = w_a_mag / w_b_mag;
        w_r_mag = w_a_mag % w_b_mag;

        if (w_is_div) begin
            // 0x80000000 / -1 falls out naturally as LO=0x80000000, HI=0.
            w_res_lo = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
            w_res_hi = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
        end else begin
            w_res_lo = w_mul_res[31:0];
            w_res_hi = w_mul_res[63:32];
        end
    end

    // Issue, countdown and HI/LO write-back; mthi/mtlo are single-cycle writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_tmp_hi <= 32'd0;
            r_tmp_lo <= 32'd0;
            r_wr     <= 1'b0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
        end else if (r_busy) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
                if (r_wr) begin
                    r_hi <= r_tmp_hi;
                    r_lo <= r_tmp_lo;
                end
            end
        end else if (w_start) begin
            r_tmp_hi <= w_res_hi;
            r_tmp_lo <= w_res_lo;
            r_wr     <= ~w_div0;
            r_busy   <= 1'b1;
            r_cnt    <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (!mdu.Req) begin
            if (w_op == MDU_mthi) begin
                r_hi <= mdu.A;
            end
            if (w_op == MDU_mtlo) begin
                r_lo <= mdu.A;
            end
        end
    end

    assign mdu.Start = w_start;
    assign mdu.Busy  = r_busy;
    assign mdu.HI    = r_hi;
    assign mdu.LO    = r_lo;
    assign mdu.Out   = (w_op == MDU_mfhi) ? r_hi :
                       (w_op == MDU_mflo) ? r_lo : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed cases followed by random ops, all
// compared against a plain-arithmetic model of HI/LO.
module tb_e_mdu;
    import e_mdu_pkg::*;

    localparam int unsigned MultN = 5;
    localparam int unsigned DivN  = 10;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    e_mdu_if mdu_if ();

    e_mdu #(
        .MULT_CYCLES(MultN),
        .DIV_CYCLES (DivN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .mdu  (mdu_if)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi     = 32'd0;
    logic [31:0] m_lo     = 32'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // The hazard unit never issues into a busy MDU; the bench must honour that too.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(mdu_if.Busy && (mdu_if.Start || mdu_if.MDUOp == 4'd5 ||
                                      mdu_if.MDUOp == 4'd6)))
            else $error("bench issued an op while Busy");
        end
    end

    function automatic bit is_multi(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd3, 4'd4: return 1'b1;
`ifdef MDU_MADD_EN
            4'd9, 4'd10, 4'd11, 4'd12: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Reference {HI,LO} after a multi-cycle op; wr=0 means HI/LO stay unchanged.
    function automatic logic [63:0] model_op(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc,
                                             output bit wr);
        int              sa;
        int              sb;
        longint          ps;
        longint unsigned pu;
        logic [63:0]     r;
        sa = a;
        sb = b;
        ps = longint'(sa) * longint'(sb);
        pu = longint'({32'd0, a}) * longint'({32'd0, b});
        wr = 1'b1;
        r  = acc;
        case (op)
            4'd1: r = ps;
            4'd2: r = pu;
            4'd3: begin
                if (b == 32'd0) wr = 1'b0;
                else if (a == 32'h8000_0000 && sb == -1) r = {32'd0, 32'h8000_0000};
                else r = {32'(sa % sb), 32'(sa / sb)};
            end
            4'd4: begin
                if (b == 32'd0) wr = 1'b0;
                else r = {a % b, a / b};
            end
            4'd9:  r = acc + ps;
            4'd10: r = acc + pu;
            4'd11: r = acc - ps;
            4'd12: r = acc - pu;
            default: wr = 1'b0;
        endcase
        return r;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit req);
        bit          mc;
        bit          wr;
        int          n;
        logic [63:0] res;
        logic [31:0] exp_out;
        @(negedge clk);
        mdu_if.MDUOp = op;
        mdu_if.A     = a;
        mdu_if.B     = b;
        mdu_if.Req   = req;
        #1;
        mc      = is_multi(op) && !req;
        exp_out = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
        check("start", mdu_if.Start, mc);
        check("out", mdu_if.Out, exp_out);
        res = model_op(op, a, b, {m_hi, m_lo}, wr);
        n   = (op == 4'd3 || op == 4'd4) ? DivN : MultN;
        @(posedge clk);
        #1;
        mdu_if.MDUOp = 4'd0;
        mdu_if.Req   = 1'b0;
        mdu_if.A     = $urandom;
        mdu_if.B     = $urandom;
        if (mc) begin
            check("busy_issue", mdu_if.Busy, 1'b1);
            check("hi_hold", mdu_if.HI, m_hi);
            for (int k = 1; k <= n; k++) begin
                @(posedge clk);
                #1;
                check("busy_run", mdu_if.Busy, (k < n));
            end
            if (wr) begin
                m_hi = res[63:32];
                m_lo = res[31:0];
            end
        end else begin
            check("busy_idle", mdu_if.Busy, 1'b0);
            if (!req && op == 4'd5) m_hi = a;
            if (!req && op == 4'd6) m_lo = a;
        end
        check("hi", mdu_if.HI, m_hi);
        check("lo", mdu_if.LO, m_lo);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'(int'($urandom_range(0, 20)) - 10);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset        = 1'b1;
        mdu_if.MDUOp = 4'd7;
        mdu_if.A     = 32'd0;
        mdu_if.B     = 32'd0;
        mdu_if.Req   = 1'b0;
        #12;
        check("rst_busy", mdu_if.Busy, 1'b0);
        check("rst_hi", mdu_if.HI, 32'd0);
        check("rst_lo", mdu_if.LO, 32'd0);
        check("rst_out", mdu_if.Out, 32'd0);
        @(negedge clk);
        reset        = 1'b0;
        mdu_if.MDUOp = 4'd0;

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("tp_mult_hi", mdu_if.HI, 32'hFFFF_FFFF);
        check("tp_mult_lo", mdu_if.LO, 32'hFFFF_FFFA);
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("tp_multu_hi", mdu_if.HI, 32'h0000_0002);
        check("tp_multu_lo", mdu_if.LO, 32'hFFFF_FFFA);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("tp_div_hi", mdu_if.HI, 32'hFFFF_FFFF);
        check("tp_div_lo", mdu_if.LO, 32'hFFFF_FFFD);

        run_op(4'd5, 32'h11, 32'd0, 1'b0);
        run_op(4'd6, 32'h22, 32'd0, 1'b0);
        run_op(4'd4, 32'd100, 32'd0, 1'b0);
        check("tp_div0_hi", mdu_if.HI, 32'h11);
        check("tp_div0_lo", mdu_if.LO, 32'h22);

        run_op(4'd1, 32'd7, 32'd9, 1'b1);
        run_op(4'd5, 32'd5, 32'd0, 1'b1);
        check("tp_req_hi", mdu_if.HI, 32'h11);

        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("tp_ovf_hi", mdu_if.HI, 32'd0);
        check("tp_ovf_lo", mdu_if.LO, 32'h8000_0000);
        run_op(4'd7, 32'd0, 32'd0, 1'b0);
        run_op(4'd8, 32'd0, 32'd0, 1'b0);
        run_op(4'd15, 32'd1, 32'd1, 1'b0);

        // Reset in the middle of a divide: clears at once and no late write-back.
        run_op(4'd5, 32'h1234, 32'd0, 1'b0);
        run_op(4'd6, 32'h5678, 32'd0, 1'b0);
        @(negedge clk);
        mdu_if.MDUOp = 4'd3;
        mdu_if.A     = 32'd50;
        mdu_if.B     = 32'd7;
        @(posedge clk);
        #1;
        mdu_if.MDUOp = 4'd0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("midrst_busy", mdu_if.Busy, 1'b0);
        check("midrst_hi", mdu_if.HI, 32'd0);
        check("midrst_lo", mdu_if.LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("midrst_late_hi", mdu_if.HI, 32'd0);
        check("midrst_late_lo", mdu_if.LO, 32'd0);
        check("midrst_busy2", mdu_if.Busy, 1'b0);
        run_op(4'd8, 32'd0, 32'd0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            run_op(4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
                   ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
